am_mod: RTL and testbench

AM_MOD -- requirements
Module: am_mod

---
 rtl/am_pkg.sv | 29 ++
 rtl/am_sine_lut.sv | 57 +++++
 rtl/am_mod.sv | 145 ++++++++++++++
 tb/tb_am_mod.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// -----------------------------------------------------------------------------
// am_pkg -- shared constants and helpers for the AM modulator.
//   CAR_W / CAR_MAX : carrier sample width and peak amplitude of the sine table
//   IDX_W / RATE_W  : modulation-index and rate-divider widths
//   ENV_W           : envelope width (unsigned)
//   ENV_OFFSET      : DC offset added to the scaled baseband to form the envelope
//   FRAC_SHIFT      : Q0.16 fraction shift used by both multipliers
//   PIPE_LAT        : enabled cycles from phase update to dac_data
// -----------------------------------------------------------------------------
package am_pkg;

  localparam int CAR_W      = 16;
  localparam int CAR_MAX    = 32767;
  localparam int IDX_W      = 16;
  localparam int RATE_W     = 16;
  localparam int ENV_W      = 16;
  localparam int ENV_OFFSET = 32768;
  localparam int FRAC_SHIFT = 16;
  localparam int PIPE_LAT   = 4;

  typedef logic [ENV_W-1:0]  env_t;
  typedef logic [RATE_W-1:0] rate_t;

  // A rate divider of zero behaves as one clock per baseband sample.
  function automatic rate_t eff_rate(input rate_t r);
    return (r == '0) ? rate_t'(1) : r;
  endfunction

endpackage

// File: rtl/am_sine_lut.sv
// -----------------------------------------------------------------------------
// am_sine_lut -- registered quarter-wave sine table, one cycle latency.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears the output)
//   i_en      : output register advances only when high
//   i_addr    : full-cycle phase address (LUT_AW bits)
//   o_sin     : signed carrier sample, amplitude +/-CAR_MAX
// Only one quadrant is stored. Entries sit at half-step offsets
// (angle = 2*pi*(j+0.5)/2^LUT_AW), so the mirrored quadrant is simply the
// bitwise complement of the in-quadrant index and no extra endpoint is needed.
// -----------------------------------------------------------------------------
module am_sine_lut
  import am_pkg::*;
#(
  parameter int LUT_AW = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic [LUT_AW-1:0]       i_addr,
  output logic signed [CAR_W-1:0] o_sin
);

  localparam int QW = LUT_AW - 2;
  localparam int QN = 1 << QW;

  function automatic int quarter_sin(input int j);
    real ang;
    ang = 2.0 * 3.14159265358979323846 * (real'(j) + 0.5) / real'(1 << LUT_AW);
    return int'(real'(CAR_MAX) * $sin(ang));
  endfunction

  logic signed [CAR_W-1:0] w_rom [QN];

  for (genvar g = 0; g < QN; g++) begin : g_rom
    assign w_rom[g] = CAR_W'(quarter_sin(g));
  end

  logic [QW-1:0]           w_idx;
  logic signed [CAR_W-1:0] w_mag;
  logic signed [CAR_W-1:0] r_sin;

  // Odd quadrants run the table backwards; the upper half-cycle is negated.
  assign w_idx = i_addr[LUT_AW-2] ? ~i_addr[QW-1:0] : i_addr[QW-1:0];
  assign w_mag = w_rom[w_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sin <= '0;
    end else if (i_en) begin
      r_sin <= i_addr[LUT_AW-1] ? -w_mag : w_mag;
    end
  end

  assign o_sin = r_sin;

endmodule

// File: rtl/am_mod.sv
// -----------------------------------------------------------------------------
// am_mod -- DDS carrier amplitude-modulated by a zero-order-held baseband.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : advances phase, slot counter and datapath; freezes all when low
//   phi_inc       : carrier phase increment per enabled clock
//   rate_div      : clocks per baseband sample (0 behaves as 1)
//   mod_index     : unsigned Q0.16 modulation depth
//   mod_data      : signed baseband sample, qualified by in_valid
//   in_ready      : a baseband slot is open this cycle
//   underrun_clr  : clears the sticky underrun flag
//   dac_data      : signed modulated output
//   dac_valid     : dac_data valid this cycle
//   underrun      : sticky, a slot passed with no valid sample
// dac_data after enabled edge n is built from the phase and held sample
// written at enabled edge n-4 (reset values count as edge 0).
// -----------------------------------------------------------------------------
module am_mod
  import am_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 16,
  parameter int LUT_AW  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [PHASE_W-1:0]       phi_inc,
  input  logic [RATE_W-1:0]        rate_div,
  input  logic [IDX_W-1:0]         mod_index,
  input  logic signed [DATA_W-1:0] mod_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     underrun_clr,
  output logic signed [DATA_W-1:0] dac_data,
  output logic                     dac_valid,
  output logic                     underrun
);

  localparam int HPROD_W = DATA_W + IDX_W + 1;
  localparam int PROD_W  = CAR_W + ENV_W + 1;

  // envelope = ENV_OFFSET + floor(hold * index / 2^16), wraps into 16 bits unsaturated
  function automatic env_t calc_env(input logic signed [DATA_W-1:0] s,
                                    input logic [IDX_W-1:0]         m);
    logic signed [HPROD_W-1:0] p;
    p = HPROD_W'(s) * HPROD_W'($signed({1'b0, m}));
    return env_t'((p >>> FRAC_SHIFT) + HPROD_W'(ENV_OFFSET));
  endfunction

  // Arithmetic shift (floor); the product is bounded so the result fits DATA_W.
  function automatic logic signed [DATA_W-1:0] scale_dac(input logic signed [PROD_W-1:0] p);
    return DATA_W'(p >>> FRAC_SHIFT);
  endfunction

  logic [PHASE_W-1:0]       r_phase;
  rate_t                    r_cnt;
  rate_t                    r_lim;
  rate_t                    w_rate;
  rate_t                    w_lim;
  logic                     w_slot0;
  logic                     w_slot_end;
  logic                     w_ready;
  logic signed [DATA_W-1:0] r_hold;
  logic                     r_underrun;
  logic [PIPE_LAT-1:0]      r_vld_p;

  logic signed [CAR_W-1:0]  w_car_p0;
  env_t                     r_env_p0;
  logic signed [CAR_W-1:0]  r_car_p1;
  env_t                     r_env_p1;
  logic signed [PROD_W-1:0] r_prod_p2;
  logic signed [DATA_W-1:0] r_dac_p3;

  // The divider is captured while the counter sits at 0, so a new rate_div
  // only shapes the slot that starts there.
  assign w_rate     = eff_rate(rate_div);
  assign w_slot0    = (r_cnt == '0);
  assign w_lim      = w_slot0 ? w_rate : r_lim;
  assign w_slot_end = (r_cnt == w_lim - rate_t'(1));
  assign w_ready    = enable & w_slot0 & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= '0;
      r_cnt      <= '0;
      r_lim      <= rate_t'(1);
      r_hold     <= '0;
      r_underrun <= 1'b0;
      r_vld_p    <= '0;
    end else begin
      if (enable) begin
        r_phase <= r_phase + phi_inc;
        r_cnt   <= w_slot_end ? '0 : r_cnt + rate_t'(1);
        r_lim   <= w_lim;
        r_vld_p <= {r_vld_p[PIPE_LAT-2:0], 1'b1};
      end
      if (w_ready && in_valid) begin
        r_hold <= mod_data;
      end
      // A missed slot takes priority over a simultaneous clear.
      if (w_ready && !in_valid) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

  am_sine_lut #(
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk    (clk),
    .rst    (rst),
    .i_en   (enable),
    .i_addr (r_phase[PHASE_W-1 -: LUT_AW]),
    .o_sin  (w_car_p0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_env_p0  <= '0;
      r_car_p1  <= '0;
      r_env_p1  <= '0;
      r_prod_p2 <= '0;
      r_dac_p3  <= '0;
    end else if (enable) begin
      // p0: envelope from the held sample, alongside the LUT read
      r_env_p0  <= calc_env(r_hold, mod_index);
      // p1: carrier and envelope aligned
      r_car_p1  <= w_car_p0;
      r_env_p1  <= r_env_p0;
      // p2: modulation product
      r_prod_p2 <= PROD_W'(r_car_p1) * PROD_W'($signed({1'b0, r_env_p1}));
      // p3: output scaling
      r_dac_p3  <= scale_dac(r_prod_p2);
    end
  end

  assign in_ready  = w_ready;
  assign dac_data  = r_dac_p3;
  assign dac_valid = enable & r_vld_p[PIPE_LAT-1];
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_am_mod.sv
// -----------------------------------------------------------------------------
// tb_am_mod -- self-checking bench for am_mod.
// A cycle model tracks enabled edges and keeps per-edge history of phase,
// held sample and modulation index; the expected output is computed straight
// from sine/envelope arithmetic on that history.
// -----------------------------------------------------------------------------
module tb_am_mod;

  localparam int PW = 32;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int HN = 8192;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable = 1'b0;
  logic [PW-1:0]        phi_inc = '0;
  logic [15:0]          rate_div = '0;
  logic [15:0]          mod_index = '0;
  logic signed [DW-1:0] mod_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 underrun_clr = 1'b0;
  logic signed [DW-1:0] dac_data;
  logic                 dac_valid;
  logic                 underrun;

  am_mod #(
    .PHASE_W (PW),
    .DATA_W  (DW),
    .LUT_AW  (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .phi_inc      (phi_inc),
    .rate_div     (rate_div),
    .mod_index    (mod_index),
    .mod_data     (mod_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .underrun_clr (underrun_clr),
    .dac_data     (dac_data),
    .dac_valid    (dac_valid),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint ph_h   [HN];
  longint hold_h [HN];
  longint mi_h   [HN];
  longint m_n, m_phase, m_hold, m_slot, m_dac;
  bit     m_under;

  function automatic longint sine_ref(input longint ph);
    longint a;
    real    r;
    a = ph >> (PW - AW);
    r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(a) + 0.5) / real'(1 << AW));
    return longint'(r);
  endfunction

  function automatic longint am_ref(input longint ph, input longint h, input longint mi);
    longint env;
    env = 32768 + ((h * mi) >>> 16);
    return (sine_ref(ph) * env) >>> 16;
  endfunction

  task automatic m_reset();
    m_n = 0; m_phase = 0; m_hold = 0; m_slot = 0; m_dac = 0; m_under = 0;
    ph_h[0] = 0; hold_h[0] = 0; mi_h[0] = 0;
  endtask

  task automatic m_update();
    bit     rdy;
    longint r;
    if (enable) begin
      rdy = (m_slot == 0);
      if (rdy && in_valid) m_hold = mod_data;
      if (rdy && !in_valid) m_under = 1;
      else if (underrun_clr) m_under = 0;
      r = (rate_div == 0) ? 1 : rate_div;
      m_slot = rdy ? r - 1 : m_slot - 1;
      m_phase = (m_phase + phi_inc) & 64'hFFFF_FFFF;
      m_n++;
      ph_h[m_n % HN]   = m_phase;
      hold_h[m_n % HN] = m_hold;
      mi_h[m_n % HN]   = mod_index;
      if (m_n >= 4)
        m_dac = am_ref(ph_h[(m_n-4) % HN], hold_h[(m_n-4) % HN], mi_h[(m_n-3) % HN]);
    end else if (underrun_clr) begin
      m_under = 0;
    end
  endtask

  // One clock: inputs already driven at the preceding negedge.
  task automatic step();
    #1;
    check("in_ready", in_ready, (enable && m_slot == 0));
    @(posedge clk);
    m_update();
    #1;
    check("dac_valid", dac_valid, (enable && m_n >= 4));
    check("dac_data", dac_data, m_dac);
    check("underrun", underrun, m_under);
    @(negedge clk);
  endtask

  // Asynchronous reset between edges, checked before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_dac_data", dac_data, 0);
    check("rst_dac_valid", dac_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic signed [15:0] d;
    logic [15:0]        m;
    int                 exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int mx, mn;
    // Carrier pinned at phase 2^30 (table peak 32767): dac = floor(32767*env/65536)
    tbl[0] = '{16'sd0,      16'd0,     16383};
    tbl[1] = '{16'sd32767,  16'd65535, 32766};
    tbl[2] = '{-16'sd32768, 16'd65535, 0};
    tbl[3] = '{16'sd16384,  16'd32768, 20479};
    tbl[4] = '{-16'sd16384, 16'd32768, 12287};
    tbl[5] = '{16'sd32767,  16'd0,     16383};
    tbl[6] = '{-16'sd1,     16'd65535, 16383};
    tbl[7] = '{16'sd1,      16'd65535, 16383};
    tbl[8] = '{16'sd12345,  16'd32768, 19469};
    tbl[9] = '{-16'sd32768, 16'd32768, 8191};

    m_reset();
    @(negedge clk);
    do_reset();

    // ---- table: envelope/output scaling at fixed carrier peak ----
    rate_div = 16'd1; enable = 1'b1; in_valid = 1'b1; mod_index = '0; mod_data = '0;
    phi_inc = 32'h4000_0000;
    step();
    phi_inc = '0;
    for (int i = 0; i < 10; i++) begin
      mod_data  = tbl[i].d;
      mod_index = tbl[i].m;
      repeat (6) step();
      check($sformatf("tbl%0d_dac", i), dac_data, tbl[i].exp);
    end

    // ---- steady carrier, mod_index 0: fill latency and half-scale peak ----
    do_reset();
    phi_inc = 32'd343597384; mod_index = '0; rate_div = 16'd1;
    enable = 1'b1; in_valid = 1'b1; mod_data = 16'sd1000;
    repeat (3) step();
    check("fill_valid_low", dac_valid, 0);
    step();
    check("fill_valid_high", dac_valid, 1);
    mx = -100000; mn = 100000;
    repeat (50) begin
      step();
      if (dac_data > mx) mx = dac_data;
      if (dac_data < mn) mn = dac_data;
    end
    check("peak_max_range", (mx <= 16383 && mx >= 16000), 1);
    check("peak_min_range", (mn >= -16384 && mn <= -16000), 1);

    // ---- freeze for 10 cycles mid-stream, then resume ----
    mod_index = 16'd40000;
    repeat (5) begin mod_data = 16'($urandom); step(); end
    enable = 1'b0;
    repeat (10) step();
    check("freeze_valid", dac_valid, 0);
    enable = 1'b1;
    repeat (12) begin mod_data = 16'($urandom); step(); end

    // ---- slot/underrun sequence with rate_div = 4 ----
    do_reset();
    rate_div = 16'd4; enable = 1'b1; phi_inc = 32'd123456789; mod_index = 16'd50000;
    mod_data = 16'sd20000; in_valid = 1'b1; underrun_clr = 1'b0;
    step();                                  // slot 0 filled
    in_valid = 1'b0; mod_data = -16'sd7;
    repeat (3) step();                       // not a slot: no underrun
    check("ur_outside_slot", underrun, 0);
    step();                                  // slot 4 missed
    check("ur_set", underrun, 1);
    underrun_clr = 1'b1; in_valid = 1'b1;
    step();
    check("ur_cleared", underrun, 0);
    underrun_clr = 1'b0;
    repeat (2) step();
    in_valid = 1'b0; underrun_clr = 1'b1;
    step();                                  // slot 8 missed while clearing
    check("ur_set_wins", underrun, 1);
    step();
    check("ur_clear_again", underrun, 0);
    underrun_clr = 1'b0; in_valid = 1'b1;
    rate_div = 16'd0;                        // takes effect at next slot start
    repeat (8) begin mod_data = 16'($urandom); step(); end

    // ---- mid-stream reset then refill ----
    do_reset();
    repeat (6) step();

    // ---- randomized run against the model ----
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      enable       = ($urandom_range(0, 9) != 0);
      in_valid     = ($urandom_range(0, 7) != 0);
      underrun_clr = ($urandom_range(0, 9) == 0);
      mod_data     = 16'($urandom);
      if ($urandom_range(0, 19) == 0) mod_index = 16'($urandom);
      if ($urandom_range(0, 49) == 0) phi_inc = $urandom;
      if ($urandom_range(0, 99) == 0) rate_div = 16'($urandom_range(0, 5));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
